// File: rtl/pacemaker_pkg.sv
// Shared types and default timing for the dual-chamber pacing controller.
// All intervals are counted in clock ticks.
package pacemaker_pkg;

  typedef enum logic {
    VA_WAIT = 1'b0,
    AV_WAIT = 1'b1
  } pace_state_e;

  localparam int unsigned DefLri   = 100;
  localparam int unsigned DefAvi   = 25;
  localparam int unsigned DefUri   = 60;
  localparam int unsigned DefPvarp = 30;
  localparam int unsigned DefVrp   = 20;
  localparam int unsigned DefPw    = 2;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int unsigned timer_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    if (max_val >= 2) w = $clog2(max_val + 1);
    return w;
  endfunction

endpackage

// File: rtl/pace_pulse_gen.sv
// Registered one-shot: a trigger starts a pulse exactly PW cycles wide.
// Triggers arriving while a pulse is in flight are ignored.
module pace_pulse_gen
  import pacemaker_pkg::*;
#(
  parameter int unsigned PW = DefPw
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trig_i,
  output logic pulse_o
);

  localparam int unsigned CW = timer_width(PW);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end else if (trig_i) begin
      cnt_d = CW'(PW);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= (cnt_d != '0);
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/ddd_pace_controller.sv
// DDD-mode pacing timing controller: VA/AV interval sequencing, upper-rate
// limiting and post-ventricular refractory windows driving two pace pulses.
module ddd_pace_controller
  import pacemaker_pkg::*;
#(
  parameter int unsigned LRI   = DefLri,
  parameter int unsigned AVI   = DefAvi,
  parameter int unsigned URI   = DefUri,
  parameter int unsigned PVARP = DefPvarp,
  parameter int unsigned VRP   = DefVrp,
  parameter int unsigned PW    = DefPw
) (
  input  logic clk,
  input  logic rst,
  input  logic sa,
  input  logic sv,
  output logic pa,
  output logic pv,
  output logic a_refr,
  output logic v_refr,
  output logic state_o
);

  localparam int unsigned VAI = LRI - AVI;
  localparam int unsigned TW  = timer_width(LRI);
  localparam int unsigned RW  = timer_width((PVARP > VRP) ? PVARP : VRP);

  localparam logic [TW-1:0] VaiLast = TW'(VAI - 1);
  localparam logic [TW-1:0] AviLast = TW'(AVI - 1);
  localparam logic [TW-1:0] UriLast = TW'(URI - 1);
  localparam logic [TW-1:0] UriSat  = TW'(URI);
  localparam logic [RW-1:0] PvarpLd = RW'(PVARP);
  localparam logic [RW-1:0] VrpLd   = RW'(VRP);

  if (LRI <= AVI) begin : g_chk_vai
    $error("ddd_pace_controller: LRI must exceed AVI");
  end
  if (URI > LRI) begin : g_chk_uri
    $error("ddd_pace_controller: URI must not exceed LRI");
  end
  if (PVARP >= VAI) begin : g_chk_pvarp
    $error("ddd_pace_controller: PVARP must be shorter than LRI-AVI");
  end
  if (PW < 1 || PW >= VRP) begin : g_chk_pw
    $error("ddd_pace_controller: PW must be at least 1 and below VRP");
  end
  if (AVI <= PW) begin : g_chk_avi
    $error("ddd_pace_controller: AVI must exceed PW");
  end

  pace_state_e   state_q;
  logic [TW-1:0] va_q, av_q, uri_q;
  logic [RW-1:0] pvarp_q, vrp_q;

  logic valid_sa, valid_sv, va_expired;
  logic a_event, a_pace, v_pace, v_event;

  assign a_refr  = (pvarp_q != '0);
  assign v_refr  = (vrp_q != '0);
  assign state_o = (state_q == AV_WAIT);

  // A valid ventricular sense always wins over any atrial decision.
  always_comb begin
    valid_sv   = sv & ~v_refr;
    valid_sa   = sa & ~a_refr & (state_q == VA_WAIT);
    va_expired = (state_q == VA_WAIT) && (va_q == VaiLast);
    v_pace     = ~valid_sv && (state_q == AV_WAIT) && (av_q >= AviLast) && (uri_q >= UriLast);
    v_event    = valid_sv | v_pace;
    a_event    = ~valid_sv & (valid_sa | va_expired);
    a_pace     = ~valid_sv & ~valid_sa & va_expired;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= VA_WAIT;
      va_q    <= '0;
      av_q    <= '0;
      uri_q   <= UriSat;
      pvarp_q <= '0;
      vrp_q   <= '0;
    end else begin
      if (v_event) begin
        pvarp_q <= PvarpLd;
        vrp_q   <= VrpLd;
      end else begin
        if (pvarp_q != '0) pvarp_q <= pvarp_q - RW'(1);
        if (vrp_q != '0)   vrp_q   <= vrp_q - RW'(1);
      end

      if (v_event) begin
        state_q <= VA_WAIT;
        va_q    <= '0;
        uri_q   <= '0;
      end else begin
        if (uri_q != UriSat) uri_q <= uri_q + TW'(1);
        if (a_event) begin
          state_q <= AV_WAIT;
          av_q    <= '0;
        end else if (state_q == VA_WAIT) begin
          va_q <= va_q + TW'(1);
        end else if (av_q != AviLast) begin
          // Holding at the AV limit lets the upper-rate timer extend AV_WAIT.
          av_q <= av_q + TW'(1);
        end
      end
    end
  end

  pace_pulse_gen #(
    .PW(PW)
  ) u_pulse_a (
    .clk_i  (clk),
    .rst_i  (rst),
    .trig_i (a_pace),
    .pulse_o(pa)
  );

  pace_pulse_gen #(
    .PW(PW)
  ) u_pulse_v (
    .clk_i  (clk),
    .rst_i  (rst),
    .trig_i (v_pace),
    .pulse_o(pv)
  );

endmodule

// File: tb/tb_ddd_pace_controller.sv
// Scoreboard bench: an event-time reference model predicts pulses and status,
// a monitor compares them against the controller cycle by cycle.
module tb_ddd_pace_controller;

  localparam int LRI   = 100;
  localparam int AVI   = 25;
  localparam int URI   = 60;
  localparam int PVARP = 30;
  localparam int VRP   = 20;
  localparam int PW    = 2;
  localparam int VAI   = LRI - AVI;
  localparam int NEVER = -100000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sa  = 1'b0;
  logic sv  = 1'b0;
  logic pa, pv, a_refr, v_refr, state_o;

  always #5 clk = ~clk;

  ddd_pace_controller #(
    .LRI  (LRI),
    .AVI  (AVI),
    .URI  (URI),
    .PVARP(PVARP),
    .VRP  (VRP),
    .PW   (PW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sa     (sa),
    .sv     (sv),
    .pa     (pa),
    .pv     (pv),
    .a_refr (a_refr),
    .v_refr (v_refr),
    .state_o(state_o)
  );

  typedef struct packed {
    logic is_v;
    int   cyc;
  } pulse_t;

  typedef struct packed {
    logic pa;
    logic pv;
    logic a_refr;
    logic v_refr;
    logic st;
  } status_t;

  pulse_t  pulse_q[$];
  status_t status_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: event times since release, not counters.
  int n, t_ref, t_a, t_vev, t_uri, last_pa, last_pv;
  bit in_av;

  task automatic model_reset();
    n = 0; t_ref = 0; t_a = NEVER; t_vev = NEVER; t_uri = NEVER;
    last_pa = NEVER; last_pv = NEVER; in_av = 0;
  endtask

  function automatic bit in_win(input int d, input int lo, input int hi);
    return (d >= lo) && (d <= hi);
  endfunction

  task automatic model_edge(input logic a, input logic v);
    bit a_ref, v_ref, vsv, vpace;
    status_t s;
    n++;
    a_ref = in_win(n - t_vev, 1, PVARP);
    v_ref = in_win(n - t_vev, 1, VRP);
    vsv   = v && !v_ref;
    vpace = !vsv && in_av && (n >= t_a + AVI) && (n >= t_uri + URI);
    if (vsv || vpace) begin
      t_ref = n; t_vev = n; t_uri = n; in_av = 0;
      if (vpace) begin
        last_pv = n;
        pulse_q.push_back('{is_v: 1'b1, cyc: n});
      end
    end else if (!in_av) begin
      if (a && !a_ref) begin
        in_av = 1; t_a = n;
      end else if (n == t_ref + VAI) begin
        in_av = 1; t_a = n; last_pa = n;
        pulse_q.push_back('{is_v: 1'b0, cyc: n});
      end
    end
    s.pa     = in_win(n - last_pa, 0, PW - 1);
    s.pv     = in_win(n - last_pv, 0, PW - 1);
    s.a_refr = in_win(n + 1 - t_vev, 1, PVARP);
    s.v_refr = in_win(n + 1 - t_vev, 1, VRP);
    s.st     = in_av;
    status_q.push_back(s);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive_cycle(input logic a, input logic v);
    @(negedge clk);
    sa = a;
    sv = v;
    model_edge(a, v);
  endtask

  task automatic wait_pulse(input bit want_v);
    int k;
    bit hit;
    k = 0;
    hit = 0;
    while (!hit && k < 400) begin
      drive_cycle(1'b0, 1'b0);
      k++;
      hit = want_v ? (last_pv == n) : (last_pa == n);
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_pulse: no %s pulse predicted within 400 cycles", want_v ? "pv" : "pa");
    end
  endtask

  task automatic sense_at(input int off, input logic a, input logic v);
    for (int i = 1; i < off; i++) drive_cycle(1'b0, 1'b0);
    drive_cycle(a, v);
    drive_cycle(1'b0, 1'b0);
  endtask

  task automatic run_random(input int cycles);
    int unsigned r;
    for (int i = 0; i < cycles; i++) begin
      r = $urandom_range(0, 299);
      drive_cycle((r < 6) || (r == 8), (r == 6) || (r == 7) || (r == 8));
    end
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    sa = 1'b0;
    sv = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compares every post-edge status and every pulse rise.
  logic    pa_p = 1'b0;
  logic    pv_p = 1'b0;
  int      nm = 0;
  status_t got_s, exp_s;
  pulse_t  exp_p;

  task automatic check_rise(input logic is_v, input int cyc);
    checks++;
    if (pulse_q.size() == 0) begin
      failures++;
      $display("FAIL pulse_rise: got %s at cycle %0d expected no pulse", is_v ? "pv" : "pa", cyc);
    end else begin
      exp_p = pulse_q.pop_front();
      if (exp_p.is_v !== is_v || exp_p.cyc != cyc) begin
        failures++;
        $display("FAIL pulse_rise: got %s at cycle %0d expected %s at cycle %0d",
                 is_v ? "pv" : "pa", cyc, exp_p.is_v ? "pv" : "pa", exp_p.cyc);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        nm = 0;
        pa_p = 1'b0;
        pv_p = 1'b0;
      end else begin
        nm++;
        got_s = '{pa: pa, pv: pv, a_refr: a_refr, v_refr: v_refr, st: state_o};
        checks++;
        if (status_q.size() == 0) begin
          failures++;
          $display("FAIL status: got %b at cycle %0d expected nothing queued", got_s, nm);
        end else begin
          exp_s = status_q.pop_front();
          if (got_s !== exp_s) begin
            failures++;
            $display("FAIL status(pa,pv,a_refr,v_refr,state) cycle %0d: got %b expected %b",
                     nm, got_s, exp_s);
          end
        end
        if (pa && !pa_p) check_rise(1'b0, nm);
        if (pv && !pv_p) check_rise(1'b1, nm);
        pa_p = pa;
        pv_p = pv;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check1("reset_pa", pa, 1'b0);
    check1("reset_pv", pv, 1'b0);
    check1("reset_a_refr", a_refr, 1'b0);
    check1("reset_v_refr", v_refr, 1'b0);
    check1("reset_state", state_o, 1'b0);
    release_reset();

    // Free-running lower-rate pacing.
    repeat (320) drive_cycle(1'b0, 1'b0);

    // Atrial sense mid-VA, inside PVARP, just after PVARP (upper-rate hold).
    wait_pulse(1'b1);
    sense_at(40, 1'b1, 1'b0);
    wait_pulse(1'b1);
    sense_at(10, 1'b1, 1'b0);
    wait_pulse(1'b1);
    sense_at(30, 1'b1, 1'b0);
    wait_pulse(1'b1);
    sense_at(31, 1'b1, 1'b0);
    // Simultaneous sa+sv outside refractory: ventricular event only.
    wait_pulse(1'b1);
    sense_at(50, 1'b1, 1'b1);
    // Ventricular sense during AV delay inhibits pv.
    wait_pulse(1'b0);
    sense_at(10, 1'b0, 1'b1);
    // Ventricular sense inside VRP is ignored.
    wait_pulse(1'b1);
    sense_at(5, 1'b0, 1'b1);

    run_random(2000);

    // Asynchronous reset in the middle of a ventricular pulse.
    wait_pulse(1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check1("midreset_pv", pv, 1'b0);
    check1("midreset_pa", pa, 1'b0);
    check1("midreset_a_refr", a_refr, 1'b0);
    check1("midreset_v_refr", v_refr, 1'b0);
    check1("midreset_state", state_o, 1'b0);
    repeat (2) @(posedge clk);
    release_reset();
    repeat (220) drive_cycle(1'b0, 1'b0);
    run_random(600);

    @(posedge clk);
    #3;
    while (pulse_q.size() != 0) begin
      exp_p = pulse_q.pop_front();
      checks++;
      failures++;
      $display("FAIL pulse_missing: got no rise expected %s at cycle %0d",
               exp_p.is_v ? "pv" : "pa", exp_p.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
